// File: rtl/if_prefetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : if_prefetch_if
//  Description : Bundle of the fetch-stage buses. It carries the redirect
//                input, the instruction-memory read port, the decode-side
//                valid/ready output and the occupancy/flush status.
//  Revision    : 1.0 - initial release
// ============================================================================
interface if_prefetch_if #(
    parameter int ROM_AW = 6,
    parameter int DEPTH  = 4
);
    logic                     redirect;
    logic [31:0]              redirect_pc;
    logic                     imem_req;
    logic [ROM_AW-1:0]        imem_addr;
    logic [31:0]              imem_rdata;
    logic                     out_valid;
    logic                     out_ready;
    logic [31:0]              out_instr;
    logic [31:0]              out_pc;
    logic                     IF_flush;
    logic [$clog2(DEPTH):0]   level;

    // Fetch-stage side
    modport master (
        input  redirect, redirect_pc, imem_rdata, out_ready,
        output imem_req, imem_addr, out_valid, out_instr, out_pc, IF_flush, level
    );

    // Environment side: branch unit, instruction memory and decode
    modport slave (
        output redirect, redirect_pc, imem_rdata, out_ready,
        input  imem_req, imem_addr, out_valid, out_instr, out_pc, IF_flush, level
    );
endinterface
`default_nettype wire

// File: rtl/if_prefetch.sv
`default_nettype none
// ============================================================================
//  Module      : if_prefetch
//  Description : Instruction-fetch stage with a DEPTH-entry prefetch queue.
//                Issues word reads to a one-cycle-latency memory, queues the
//                returned {pc, instr} pairs and drains them to decode over
//                valid/ready. A redirect flushes the queue and the in-flight
//                read.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_prefetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ROM_AW   = 6,
    parameter int          DEPTH    = 4
) (
    input  wire logic       clk,
    input  wire logic       reset,
    if_prefetch_if.master   bus
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam int c_depth_int = DEPTH;
    localparam logic [c_cnt_w:0] c_depth_ext = c_depth_int[c_cnt_w:0];

    logic [31:0]        r_fetch_pc;
    logic               r_inflight;
    logic [31:0]        r_tag;
    logic [c_cnt_w-1:0] r_count;
    logic [c_ptr_w-1:0] r_wptr;
    logic [c_ptr_w-1:0] r_rptr;

    logic [31:0]        r_q_pc    [DEPTH];
    logic [31:0]        r_q_instr [DEPTH];

    logic [c_cnt_w:0]   w_credit;
    logic               w_req;
    logic               w_push;
    logic               w_pop;
    logic               w_nonempty;
    logic               w_unused;

    // Credit counts the outstanding read so a response always finds room;
    // a same-cycle pop is ignored on purpose to keep the issue path short.
    assign w_credit   = {1'b0, r_count} + {{c_cnt_w{1'b0}}, r_inflight};
    assign w_req      = reset && !bus.redirect && (w_credit < c_depth_ext);
    assign w_push     = r_inflight && !bus.redirect;
    assign w_nonempty = (r_count != '0);
    assign w_pop      = w_nonempty && bus.out_ready && !bus.redirect;

    // Low redirect bits are forced to zero, so they are intentionally dropped.
    assign w_unused   = ^bus.redirect_pc[1:0];

    assign bus.imem_req  = w_req;
    assign bus.imem_addr = r_fetch_pc[ROM_AW+1:2];
    assign bus.out_valid = reset && w_nonempty;
    assign bus.out_instr = r_q_instr[r_rptr];
    assign bus.out_pc    = r_q_pc[r_rptr];
    assign bus.IF_flush  = bus.redirect;
    assign bus.level     = reset ? r_count : '0;

    // Fetch PC, in-flight tracking and queue pointers/occupancy
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_fetch_pc <= RESET_PC;
            r_inflight <= 1'b0;
            r_tag      <= '0;
            r_count    <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
        end else if (bus.redirect) begin
            r_fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
            r_inflight <= 1'b0;
            r_count    <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
        end else begin
            r_inflight <= w_req;
            if (w_req) begin
                r_tag      <= r_fetch_pc;
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Queue storage: the response is written at the tail when it is accepted
    always_ff @(posedge clk) begin
        if (reset && w_push) begin
            r_q_pc[r_wptr]    <= r_tag;
            r_q_instr[r_wptr] <= bus.imem_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_prefetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_prefetch
//  Description : Directed, table-driven bench for if_prefetch with a
//                one-cycle-latency memory holding 32'hA000_0000 + word index.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_prefetch;

    logic clk;
    logic reset;

    if_prefetch_if #(.ROM_AW(6), .DEPTH(4)) bus ();

    if_prefetch #(
        .RESET_PC (32'h0000_0000),
        .ROM_AW   (6),
        .DEPTH    (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: one-cycle read latency
    always @(posedge clk) begin
        if (bus.imem_req) begin
            bus.imem_rdata <= 32'hA000_0000 + {26'b0, bus.imem_addr};
        end
    end

    typedef struct {
        bit        rst_n;
        bit        redir;
        bit [31:0] rpc;
        bit        rdy;
        bit        e_req;
        bit [5:0]  e_addr;
        bit        e_valid;
        bit [31:0] e_pc;
        bit [2:0]  e_level;
        bit        e_flush;
    } vec_t;

    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(bit rst_n, bit redir, bit [31:0] rpc, bit rdy,
                                bit e_req, bit [5:0] e_addr, bit e_valid,
                                bit [31:0] e_pc, bit [2:0] e_level, bit e_flush);
        vec_t v;
        v.rst_n = rst_n; v.redir = redir; v.rpc = rpc; v.rdy = rdy;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_pc = e_pc; v.e_level = e_level; v.e_flush = e_flush;
        return v;
    endfunction

    function automatic logic [31:0] exp_instr(logic [31:0] pc);
        return 32'hA000_0000 + {26'b0, pc[7:2]};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one cycle: drive after the edge, leave outputs to settle to the
    // falling edge where the caller samples them.
    task automatic step(bit rst_n, bit redir, bit [31:0] rpc, bit rdy);
        @(posedge clk);
        #1;
        reset           = rst_n;
        bus.redirect    = redir;
        bus.redirect_pc = rpc;
        bus.out_ready   = rdy;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        bit seen;
        reset           = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.out_ready   = 1'b1;

        //           rst red rpc      rdy  req addr val pc        lvl flush
        // Reset, then free-run
        tbl.push_back(mk(0, 0, 32'h0,  1,  0, 6'd0,  0, 32'h0,    0, 0));
        tbl.push_back(mk(0, 0, 32'h0,  1,  0, 6'd0,  0, 32'h0,    0, 0));
        tbl.push_back(mk(1, 0, 32'h0,  1,  1, 6'd0,  0, 32'h0,    0, 0));
        tbl.push_back(mk(1, 0, 32'h0,  1,  1, 6'd1,  0, 32'h0,    0, 0));
        tbl.push_back(mk(1, 0, 32'h0,  1,  1, 6'd2,  1, 32'h0,    1, 0));
        tbl.push_back(mk(1, 0, 32'h0,  1,  1, 6'd3,  1, 32'h4,    1, 0));
        // Backpressure: fill to DEPTH, requests stop, head stays stable
        tbl.push_back(mk(1, 0, 32'h0,  0,  1, 6'd4,  1, 32'h8,    1, 0));
        tbl.push_back(mk(1, 0, 32'h0,  0,  1, 6'd5,  1, 32'h8,    2, 0));
        tbl.push_back(mk(1, 0, 32'h0,  0,  0, 6'd0,  1, 32'h8,    3, 0));
        tbl.push_back(mk(1, 0, 32'h0,  0,  0, 6'd0,  1, 32'h8,    4, 0));
        tbl.push_back(mk(1, 0, 32'h0,  0,  0, 6'd0,  1, 32'h8,    4, 0));
        // Release: in-order drain, no gaps or duplicates
        tbl.push_back(mk(1, 0, 32'h0,  1,  0, 6'd0,  1, 32'h8,    4, 0));
        tbl.push_back(mk(1, 0, 32'h0,  1,  1, 6'd6,  1, 32'hC,    3, 0));
        tbl.push_back(mk(1, 0, 32'h0,  1,  1, 6'd7,  1, 32'h10,   2, 0));
        tbl.push_back(mk(1, 0, 32'h0,  1,  1, 6'd8,  1, 32'h14,   2, 0));
        tbl.push_back(mk(1, 0, 32'h0,  1,  1, 6'd9,  1, 32'h18,   2, 0));
        tbl.push_back(mk(1, 0, 32'h0,  0,  1, 6'd10, 1, 32'h1C,   2, 0));
        // Redirect with credit exhausted (3 queued + 1 in flight) to 0x24
        tbl.push_back(mk(1, 1, 32'h24, 0,  0, 6'd0,  1, 32'h1C,   3, 1));
        tbl.push_back(mk(1, 0, 32'h0,  1,  1, 6'd9,  0, 32'h0,    0, 0));
        tbl.push_back(mk(1, 0, 32'h0,  1,  1, 6'd10, 0, 32'h0,    0, 0));
        tbl.push_back(mk(1, 0, 32'h0,  1,  1, 6'd11, 1, 32'h24,   1, 0));
        tbl.push_back(mk(1, 0, 32'h0,  1,  1, 6'd12, 1, 32'h28,   1, 0));
        // Redirect coinciding with pop and response, unaligned target 0x1E
        tbl.push_back(mk(1, 1, 32'h1E, 1,  0, 6'd0,  1, 32'h2C,   1, 1));
        tbl.push_back(mk(1, 0, 32'h0,  1,  1, 6'd7,  0, 32'h0,    0, 0));
        tbl.push_back(mk(1, 0, 32'h0,  1,  1, 6'd8,  0, 32'h0,    0, 0));
        tbl.push_back(mk(1, 0, 32'h0,  1,  1, 6'd9,  1, 32'h1C,   1, 0));
        tbl.push_back(mk(1, 0, 32'h0,  0,  1, 6'd10, 1, 32'h20,   1, 0));
        // Reset mid-stream with entries queued and a read in flight
        tbl.push_back(mk(0, 0, 32'h0,  0,  0, 6'd0,  0, 32'h0,    0, 0));
        tbl.push_back(mk(0, 0, 32'h0,  0,  0, 6'd0,  0, 32'h0,    0, 0));
        tbl.push_back(mk(1, 0, 32'h0,  1,  1, 6'd0,  0, 32'h0,    0, 0));
        tbl.push_back(mk(1, 0, 32'h0,  1,  1, 6'd1,  0, 32'h0,    0, 0));
        tbl.push_back(mk(1, 0, 32'h0,  1,  1, 6'd2,  1, 32'h0,    1, 0));
        // PC passing the top of the memory: 0xF8, 0xFC, 0x100 aliases word 0
        tbl.push_back(mk(1, 1, 32'hF8, 1,  0, 6'd0,  1, 32'h4,    1, 1));
        tbl.push_back(mk(1, 0, 32'h0,  1,  1, 6'd62, 0, 32'h0,    0, 0));
        tbl.push_back(mk(1, 0, 32'h0,  1,  1, 6'd63, 0, 32'h0,    0, 0));
        tbl.push_back(mk(1, 0, 32'h0,  1,  1, 6'd0,  1, 32'hF8,   1, 0));
        tbl.push_back(mk(1, 0, 32'h0,  1,  1, 6'd1,  1, 32'hFC,   1, 0));
        tbl.push_back(mk(1, 0, 32'h0,  1,  1, 6'd2,  1, 32'h100,  1, 0));
        tbl.push_back(mk(1, 0, 32'h0,  1,  1, 6'd3,  1, 32'h104,  1, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst_n, tbl[i].redir, tbl[i].rpc, tbl[i].rdy);
            chk($sformatf("row%0d imem_req", i), {31'b0, bus.imem_req}, {31'b0, tbl[i].e_req});
            if (tbl[i].e_req)
                chk($sformatf("row%0d imem_addr", i), {26'b0, bus.imem_addr}, {26'b0, tbl[i].e_addr});
            chk($sformatf("row%0d out_valid", i), {31'b0, bus.out_valid}, {31'b0, tbl[i].e_valid});
            if (tbl[i].e_valid) begin
                chk($sformatf("row%0d out_pc", i), bus.out_pc, tbl[i].e_pc);
                chk($sformatf("row%0d out_instr", i), bus.out_instr, exp_instr(tbl[i].e_pc));
            end
            chk($sformatf("row%0d level", i), {29'b0, bus.level}, {29'b0, tbl[i].e_level});
            chk($sformatf("row%0d IF_flush", i), {31'b0, bus.IF_flush}, {31'b0, tbl[i].e_flush});
        end

        // Redirect-to-valid latency, bounded wait
        step(1, 1, 32'h40, 1);
        chk("redir40 IF_flush", {31'b0, bus.IF_flush}, 32'd1);
        lat  = 0;
        seen = 1'b0;
        for (int k = 1; k <= 8 && !seen; k++) begin
            step(1, 0, 32'h0, 1);
            if (bus.out_valid) begin
                seen = 1'b1;
                lat  = k;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL redir40 wait: got no out_valid expected valid within 8 cycles");
        end else begin
            chk("redir40 latency", lat, 32'd3);
            chk("redir40 out_pc", bus.out_pc, 32'h40);
            chk("redir40 out_instr", bus.out_instr, 32'hA000_0010);
        end

        // Sustained one-per-cycle throughput with level holding at 1
        for (int k = 1; k <= 12; k++) begin
            step(1, 0, 32'h0, 1);
            chk($sformatf("stream%0d out_valid", k), {31'b0, bus.out_valid}, 32'd1);
            chk($sformatf("stream%0d out_pc", k), bus.out_pc, 32'h40 + 32'(k * 4));
            chk($sformatf("stream%0d level", k), {29'b0, bus.level}, 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
